// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad scanner.
// State codes, column reset pattern and key lookup helpers.
package keypad_pkg;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] RELEASE  = 2'd2;

  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [3:0] key_lut(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = 4'hE;
      4'hD:    k = 4'h0;
      4'hE:    k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Lowest-index zero; only meaningful when exactly one row is low.
  function automatic logic [1:0] zero_idx(input logic [3:0] r);
    logic [1:0] i;
    if (!r[0])      i = 2'd0;
    else if (!r[1]) i = 2'd1;
    else if (!r[2]) i = 2'd2;
    else            i = 2'd3;
    return i;
  endfunction

  function automatic logic one_zero(input logic [3:0] r);
    return $countones(~r) == 1;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Reset loads a configurable idle value into both stages.
module sync_2ff #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with tick-based debounce.
// Accepted keys shift into N, newest nibble at N[3:0].
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [15:0] N,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_REL = CW'(DEBOUNCE_TICKS);

  logic [3:0]    row_s;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    state;
  logic [1:0]    col_idx;
  logic [1:0]    col_nxt;
  logic [1:0]    cap_col;
  logic [3:0]    cap_row;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    key;

  sync_2ff #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign tick    = (div == DIV_MAX);
  assign col_nxt = col_idx + 2'd1;
  assign cnt_inc = cnt + 1'b1;
  assign key     = key_lut(zero_idx(cap_row), cap_col);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div       <= '0;
      state     <= SCAN;
      col_idx   <= 2'd0;
      col       <= COL_RESET;
      cap_row   <= 4'hF;
      cap_col   <= 2'd0;
      cnt       <= '0;
      N         <= 16'h0000;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      div       <= tick ? '0 : div + 1'b1;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (row_s == 4'hF) begin
              col_idx <= col_nxt;
              col     <= col_drive(col_nxt);
            end else begin
              cap_row <= row_s;
              cap_col <= col_idx;
              cnt     <= CW'(1);
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_s != cap_row) begin
              state   <= SCAN;
              col_idx <= col_nxt;
              col     <= col_drive(col_nxt);
            end else if (cnt < CNT_ACC) begin
              cnt <= cnt_inc;
            end else begin
              if (one_zero(cap_row)) begin
                key_valid <= 1'b1;
                key_code  <= key;
                N         <= {N[11:0], key};
              end
              cnt   <= '0;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (row_s != 4'hF) begin
              cnt <= '0;
            end else if (cnt_inc == CNT_REL) begin
              cnt     <= '0;
              state   <= SCAN;
              col_idx <= col_nxt;
              col     <= col_drive(col_nxt);
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= SCAN;
        endcase
      end
      // Clear wins over a same-cycle shift.
      if (clr) N <= 16'h0000;
    end
  end

endmodule
